fixed_to_float_denorm: RTL and testbench
========================================

# fixed_to_float_denorm

Converts a signed fixed-point sample back to IEEE-754 single precision. It is the inverse of the float-to-fixed normalisers, and turns fixed-point I/V processing results into float for the downstream float datapath. The conversion is sequential, with a Begin/ACK handshake. Normalisation uses a one-bit-per-cycle leading-zero shift, so latency depends on the data.

## Interface
Parameters:
- W, 32, input width; legal range 24..32.
- FRAC, 26, fractional bits of the input; value = FX · 2^-FRAC; legal range 0..W-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- FX  in  W  signed two's-complement fixed-point operand.
- Begin_FSM_FX  in  1  start request, sampled only in IDLE.
- ACK_FX  out  1  one-cycle pulse; RESULT is valid from this cycle on.
- BUSY  out  1  high in every state except IDLE.
- RESULT  out  32  IEEE-754 single: sign, 8-bit exponent, 23-bit mantissa.

## Operation
- Reset, asynchronous, forced while RST=1: state=IDLE, ACK_FX=0, BUSY=0, RESULT=0, internal registers=0.
- States: IDLE, ABS, NORM, ZERO, PACK.
- IDLE, Begin_FSM_FX=1 at edge: capture FX into reg X; go to ABS.
- ABS:
  - S = X[W-1].
  - MAG = S ? -X : X, held as a W-bit unsigned value, so -2^(W-1) gives 2^(W-1).
  - LZ = 0.
  - Go to ZERO if MAG==0, else go to NORM.
- NORM:
  - If MAG[W-1]==1, go to PACK.
  - Else MAG <= MAG<<1 and LZ <= LZ+1; stay in NORM.
  - LZ counter is 6 bits.
- PACK:
  - RESULT <= {S, E, MAG[W-2 -: 23]}.
  - E = (W-1-LZ) - FRAC + 127, computed in at least 9 bits.
  - Mantissa is truncated toward zero magnitude; no rounding. With W=24 the mantissa is MAG[22:0] exactly.
  - ACK_FX <= 1; go to IDLE.
- ZERO: RESULT <= 0x00000000 (+0, never -0); ACK_FX <= 1; go to IDLE.
- ACK_FX is registered. It is high for exactly the one cycle after the PACK/ZERO edge and cleared on the next edge.
- Exponent range is guaranteed normal by the parameter limits; no overflow, underflow or denormal handling is required. With the defaults, E spans 101..132.
- RESULT holds its value until the next PACK/ZERO edge or reset. FX may change freely after the capture edge.

## Timing
- Edge numbering: e0 is the edge on which Begin is sampled in IDLE.
- Nonzero input, L = leading zeros of MAG (0..W-1):
  - e1 is ABS.
  - e2..e(1+L) are shifts.
  - e(2+L) leaves NORM.
  - e(3+L) is PACK: RESULT updates and ACK_FX rises.
  - ACK_FX falls at e(4+L).
  - Latency is L+3 edges: minimum 3, maximum W+2.
- Zero input: RESULT/ACK_FX update at e2.
- BUSY rises at e0 and falls at the edge that asserts ACK_FX, so BUSY=0 during the ACK cycle.
- Back-to-back: Begin high during the ACK cycle is sampled in IDLE, and that edge becomes the new e0.
- Begin while BUSY=1: ignored, with no queuing.
- RST asserted mid-conversion: immediate return to reset values; no ACK for the aborted operation.
- Begin held continuously: a new conversion starts on every IDLE edge.

## Test plan
- FX=0x04000000 (1.0, L=5) -> RESULT=0x3F800000; ACK_FX high only after e8; BUSY high e0..e8.
- FX=0xFC000000 (-1.0) -> 0xBF800000. FX=0x80000000 (-32.0, L=0) -> 0xC2000000, ACK after e3.
- FX=0x00000000 -> 0x00000000, ACK after e2. FX=0x00000001 (2^-26, L=31) -> 0x32800000, ACK after e34.
- FX=0x07FFFFFF (truncation case) -> 0x3FFFFFFF.
- Begin pulsed at e5 of a running conversion -> ignored: exactly one ACK and the original RESULT. Begin in the ACK cycle with FX=0x02000000 -> 0x3F000000, ACK 9 edges later (L=6).
- RST pulsed mid-NORM on FX=0x00000001 -> ACK_FX=0, BUSY=0, RESULT=0 immediately, with no later ACK. Then FX=0x04000000 converts normally.

Source files
------------

// File: rtl/fixed_to_float_denorm_if.sv
// Begin/ACK handshake bundle between a fixed-point producer
// and the float converter.
interface fixed_to_float_denorm_if #(
  parameter int W = 32
);
  logic [W-1:0] FX;
  logic         Begin_FSM_FX;
  logic         ACK_FX;
  logic         BUSY;
  logic [31:0]  RESULT;

  modport master (
    output FX, Begin_FSM_FX,
    input  ACK_FX, BUSY, RESULT
  );

  modport slave (
    input  FX, Begin_FSM_FX,
    output ACK_FX, BUSY, RESULT
  );
endinterface

// File: rtl/fixed_to_float_denorm.sv
// Signed fixed-point to IEEE-754 single converter with a
// bit-serial leading-zero normaliser and truncating mantissa.
module fixed_to_float_denorm #(
  parameter int W    = 32,
  parameter int FRAC = 26
) (
  input logic CLK,
  input logic RST,
  fixed_to_float_denorm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    NORM = 3'd2,
    ZERO = 3'd3,
    PACK = 3'd4
  } state_t;

  localparam int EB = W - 1 - FRAC + 127;

  state_t       state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] mag_q, mag_d;
  logic [5:0]   lz_q, lz_d;
  logic         s_q, s_d;
  logic [31:0]  res_q, res_d;
  logic         ack_q, ack_d;
  logic [7:0]   exp_w;

  // Biased exponent always lands in the normal range, so the
  // low byte of the difference is the exact field value.
  assign exp_w = 8'(EB) - {2'b00, lz_q};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mag_d   = mag_q;
    lz_d    = lz_q;
    s_d     = s_q;
    res_d   = res_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Begin_FSM_FX) begin
          x_d     = bus.FX;
          state_d = ABS;
        end
      end
      ABS: begin
        s_d     = x_q[W-1];
        mag_d   = x_q[W-1] ? (W'(0) - x_q) : x_q;
        lz_d    = 6'd0;
        state_d = (x_q == '0) ? ZERO : NORM;
      end
      NORM: begin
        if (mag_q[W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 6'd1;
        end
      end
      PACK: begin
        res_d   = {s_q, exp_w, mag_q[W-2 -: 23]};
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        res_d   = 32'h0000_0000;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      mag_q   <= '0;
      lz_q    <= '0;
      s_q     <= 1'b0;
      res_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mag_q   <= mag_d;
      lz_q    <= lz_d;
      s_q     <= s_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ACK_FX = ack_q;
  assign bus.BUSY   = (state_q != IDLE);
  assign bus.RESULT = res_q;

endmodule

// File: tb/tb_fixed_to_float_denorm.sv
// Self-checking bench: vector table, handshake corner cases and
// random operands against an arithmetic float model.
module tb_fixed_to_float_denorm;

  localparam int W    = 32;
  localparam int FRAC = 26;

  logic CLK;
  logic RST;

  fixed_to_float_denorm_if #(.W(W)) ifc ();

  fixed_to_float_denorm #(.W(W), .FRAC(FRAC)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [31:0] fx;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: value = FX * 2^-FRAC, rendered as a truncated single.
  function automatic void model(input logic [31:0] fx,
                                output logic [31:0] r,
                                output int lat);
    longint v, m, mant;
    int p, e;
    v = longint'($signed(fx));
    m = (v < 0) ? -v : v;
    if (m == 0) begin
      r   = 32'h0;
      lat = 2;
      return;
    end
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = p - FRAC + 127;
    if (p >= 23) mant = m >> (p - 23);
    else         mant = m << (23 - p);
    mant = mant & 64'h7F_FFFF;
    r   = {fx[31], 8'(e), 23'(mant)};
    lat = (31 - p) + 3;
  endfunction

  // Called at #1 after an edge; the next edge becomes e0.
  task automatic start(input logic [31:0] fx);
    ifc.FX = fx;
    ifc.Begin_FSM_FX = 1'b1;
    @(posedge CLK); #1;
    ifc.Begin_FSM_FX = 1'b0;
    ifc.FX = $urandom;
  endtask

  // Called at #1 after e0; returns the edge index where ACK showed.
  task automatic wait_ack(output int n, output logic [31:0] res);
    n = 0;
    while (!ifc.ACK_FX && n < 100) begin
      if (!ifc.BUSY) begin
        n_fail++;
        $display("FAIL busy_before_ack: got 0 expected 1 at e%0d", n);
      end
      @(posedge CLK); #1;
      n++;
    end
    res = ifc.RESULT;
  endtask

  task automatic run_one(input string name, input logic [31:0] fx,
                         input logic [31:0] er, input int el);
    int n;
    logic [31:0] r;
    start(fx);
    wait_ack(n, r);
    chk({name, "_lat"}, n, el);
    chk({name, "_res"}, r, er);
    chk({name, "_busy_ack"}, ifc.BUSY, 0);
    @(posedge CLK); #1;
    chk({name, "_ack_fall"}, ifc.ACK_FX, 0);
    chk({name, "_hold"}, ifc.RESULT, er);
  endtask

  initial begin
    int n, acks, el;
    logic [31:0] r, er, fx;

    n_cmp  = 0;
    n_fail = 0;
    ifc.FX = '0;
    ifc.Begin_FSM_FX = 1'b0;
    RST = 1'b1;

    vecs[0] = '{32'h0400_0000, 32'h3F80_0000, 8};
    vecs[1] = '{32'hFC00_0000, 32'hBF80_0000, 8};
    vecs[2] = '{32'h8000_0000, 32'hC200_0000, 3};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 2};
    vecs[4] = '{32'h0000_0001, 32'h3280_0000, 34};
    vecs[5] = '{32'h07FF_FFFF, 32'h3FFF_FFFF, 8};
    vecs[6] = '{32'h0200_0000, 32'h3F00_0000, 9};
    vecs[7] = '{32'h7FFF_FFFF, 32'h41FF_FFFF, 4};
    vecs[8] = '{32'hFFFF_FFFF, 32'hB280_0000, 34};
    vecs[9] = '{32'hFFFF_FFFE, 32'hB300_0000, 33};

    #12;
    chk("rst_ack", ifc.ACK_FX, 0);
    chk("rst_busy", ifc.BUSY, 0);
    chk("rst_res", ifc.RESULT, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    foreach (vecs[i])
      run_one($sformatf("vec%0d", i), vecs[i].fx, vecs[i].res,
              vecs[i].lat);

    // Begin during a running conversion is dropped.
    start(32'h0400_0000);
    repeat (4) begin @(posedge CLK); #1; end
    ifc.FX = 32'h1234_5678;
    ifc.Begin_FSM_FX = 1'b1;
    @(posedge CLK); #1;
    ifc.Begin_FSM_FX = 1'b0;
    acks = 0;
    r = '0;
    for (int k = 0; k < 20; k++) begin
      if (ifc.ACK_FX) begin
        acks++;
        r = ifc.RESULT;
      end
      @(posedge CLK); #1;
    end
    chk("busy_begin_acks", acks, 1);
    chk("busy_begin_res", r, 32'h3F80_0000);

    // Back-to-back: Begin raised in the ACK cycle.
    start(32'h0400_0000);
    wait_ack(n, r);
    chk("b2b_first_res", r, 32'h3F80_0000);
    start(32'h0200_0000);
    wait_ack(n, r);
    chk("b2b_second_lat", n, 9);
    chk("b2b_second_res", r, 32'h3F00_0000);
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of normalisation.
    start(32'h0000_0001);
    repeat (6) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    chk("abort_ack", ifc.ACK_FX, 0);
    chk("abort_busy", ifc.BUSY, 0);
    chk("abort_res", ifc.RESULT, 0);
    @(negedge CLK);
    RST = 1'b0;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (ifc.ACK_FX) acks++;
    end
    chk("abort_no_ack", acks, 0);
    run_one("post_abort", 32'h0400_0000, 32'h3F80_0000, 8);

    // Random operands spread over every leading-zero count.
    for (int t = 0; t < 200; t++) begin
      fx = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) fx = -fx;
      if ($urandom_range(0, 15) == 0) fx = '0;
      model(fx, er, el);
      start(fx);
      wait_ack(n, r);
      if (n != el || r != er) begin
        n_fail++;
        $display("FAIL rand%0d fx=0x%08h: got 0x%08h/%0d expected 0x%08h/%0d",
                 t, fx, r, n, er, el);
      end
      n_cmp++;
      @(posedge CLK); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
